mux_rr_stream: RTL and testbench
================================

# mux_rr_stream

Parametrised N-channel stream multiplexer with a registered output and valid/ready handshaking on every port. Each input channel offers a DW-bit word. A per-cycle arbiter picks one channel, either round-robin or directly selected, and transfers its word into a single output register. It is the next generation of the team's combinational select-line muxes and sits between multiple producers and one shared downstream consumer.

## Interface
- N_CH, default 8: number of input channels, 2..64.
- DW, default 8: data width per channel, ≥1.
- SELW, default $clog2(N_CH): width of the select and channel-ID fields.

- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in  input  N_CH*DW  packed channel data; channel i occupies bits [i*DW +: DW].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; one-hot or zero.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- out  output  DW  registered output data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.
- out_ch  output  SELW  index of the channel that supplied `out`.

## Operation
- load_en = !out_valid || out_ready. The output register can accept a new word this cycle.
- Eligible set:
  - mode=1: all i with in_valid[i].
  - mode=0: only i = sel, and only if in_valid[sel]=1 and sel < N_CH.
  - sel ≥ N_CH: nothing is eligible and nothing is granted.
- Round-robin rule:
  - Search starts at index ptr+1 and wraps modulo N_CH.
  - The first eligible channel found is granted.
  - ptr is the index of the last round-robin grant.
- grant = load_en && (eligible set non-empty). in_ready[g] = 1 only for the granted g. All other in_ready bits are 0.
- A transfer on channel g occurs when in_valid[g] && in_ready[g]. On a transfer:
  - out ← the channel's word.
  - out_ch ← g.
  - out_valid ← 1.
  - If mode=1, ptr ← g.
- No grant while load_en=1: out_valid ← 0. out and out_ch hold their values.
- load_en=0 (stalled): out, out_ch and out_valid hold. All in_ready are 0.
- Direct-select grants (mode=0) do not update ptr.
- mode and sel are sampled every cycle. A change affects only the next arbitration and never alters a word already held in the register.
- in_ready depends combinationally on in_valid, mode, sel, out_ready and state. Producers must not make in_valid depend on in_ready.

## Timing
- Reset values: out=0, out_valid=0, out_ch=0, ptr=N_CH-1 (so the first round-robin search starts at channel 0). All in_ready are 0 while rst=1.
- Latency: a transfer in cycle t is visible on out/out_valid in cycle t+1.
- Throughput: one word per cycle when out_ready is held at 1. Back-to-back transfers are allowed, including consecutive words from the same channel.
- Simultaneous events: in the same cycle, the downstream pop (out_valid && out_ready) and a new upstream transfer both happen; the new word replaces the old one.
- Fairness: with all channels valid in mode=1 and out_ready=1, grants cycle 0,1,…,N_CH-1,0… with no gaps.
- Reset asserted mid-operation: the held word is discarded immediately (asynchronously) and ptr returns to N_CH-1.
- On reset release, the first transfer can occur on the first rising edge with rst=0.

## Structure
- Shared package mux_pkg holds:
  - MODE_DIRECT=1'b0 and MODE_RR=1'b1.
  - A function clog2_min1, which returns at least 1 so that SELW is never 0.
- One sub-module, rr_arbiter (parameter N), with:
  - inputs: req[N], ptr[SELW], en.
  - outputs: gnt one-hot [N], gnt_idx[SELW], any.
  - Implementation: combinational double-width priority scan.
- The top level contains the eligibility mask, the mode mux for direct select, the ptr register and the output register.

## Test plan
- Reset value check, N_CH=8, DW=8: assert rst for 3 cycles, deassert.
  - During reset: out=0, out_valid=0, out_ch=0, in_ready=0.
  - After release: first RR grant with all valid goes to ch0.
- Round-robin rotation: mode=1, all 8 valid, in[i]=8'hA0+i, out_ready=1.
  - out sequence A0..A7, then A0.
  - out_ch follows 0..7, one word per cycle.
- Round-robin skip: mode=1, only ch2 and ch5 valid → grants alternate 2,5,2. After dropping ch5 → grants stay on ch2 every cycle.
- Direct select: mode=0, sel=3, all valid → only in_ready[3]=1 and out_ch=3 continuously.
  - sel=3 with in_valid[3]=0 → out_valid falls to 0 after one cycle.
  - N_CH=6 with sel=7 → no grant.
- Back-pressure: out_ready=0 for 4 cycles with out_valid=1.
  - out is stable and all in_ready are 0.
  - When out_ready rises, a pop and a new load happen in the same cycle, with no lost or duplicated word (scoreboard count check).
- Reset mid-stream: assert rst while out_valid=1 and ptr=4.
  - out_valid drops before the next edge.
  - After release with all valid, mode=1 → first grant goes to ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the round-robin stream mux.
// Mode encodings and a select-width helper that never returns zero.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Smallest w with 2**w >= n, clamped to at least 1 bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) r = k + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over N requesters.
// The search starts just after ptr and wraps, via a double-width scan.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 8,
    parameter int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   sh;
    logic           found;
    int             start;
    int             idx;

    assign req2 = {req, req};
    assign any  = |req;

    // Rotate so the slot after ptr lands at bit 0, then take the lowest hit.
    always_comb begin
        start   = (int'(ptr) >= N - 1) ? 0 : int'(ptr) + 1;
        sh      = N'(req2 >> start);
        found   = 1'b0;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && sh[k]) begin
                found = 1'b1;
                idx   = start + k;
            end
        end
        if (idx >= N) idx = idx - N;
        if (en && found) begin
            gnt     = N'(1) << idx;
            gnt_idx = SELW'(idx);
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel valid/ready stream mux with registered output.
// Channels are picked round-robin or by direct select into one register.
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int DW   = 8,
    parameter int SELW = clog2_min1(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   in,
    input  logic [N_CH-1:0]      in_valid,
    output logic [N_CH-1:0]      in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [DW-1:0]        out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    logic            load_en;
    logic            en;
    logic [N_CH-1:0] dmask;
    logic [N_CH-1:0] arb_gnt;
    logic [SELW-1:0] arb_idx;
    logic            arb_any;
    logic [N_CH-1:0] gsel;
    logic [SELW-1:0] gch;
    logic            grant;
    logic [DW-1:0]   word;
    logic [SELW-1:0] ptr;

    assign load_en = !out_valid || out_ready;
    assign en      = load_en && !rst;

    // Direct-select eligibility; an out-of-range sel matches no channel.
    always_comb begin
        dmask = '0;
        for (int i = 0; i < N_CH; i++) begin
            dmask[i] = in_valid[i] && (sel == SELW'(i));
        end
    end

    rr_arbiter #(
        .N    (N_CH),
        .SELW (SELW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (en),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Mode mux between the round-robin grant and the direct select.
    always_comb begin
        gsel  = '0;
        gch   = '0;
        grant = 1'b0;
        if (mode == MODE_RR) begin
            gsel  = arb_gnt;
            gch   = arb_idx;
            grant = en && arb_any;
        end else begin
            gsel  = en ? dmask : '0;
            gch   = sel;
            grant = en && (|dmask);
        end
    end

    assign in_ready = gsel;

    // One-hot data select of the granted channel's word.
    always_comb begin
        word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gsel[i]) word = word | in[i*DW +: DW];
        end
    end

    // Round-robin pointer; only round-robin grants move it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= SELW'(N_CH - 1);
        end else if (grant && mode == MODE_RR) begin
            ptr <= gch;
        end
    end

    // Output register: load on grant, drain to empty when nothing granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (load_en) begin
            if (grant) begin
                out       <= word;
                out_ch    <= gch;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: directed scoreboard bench for mux_rr_stream.
// Stimulus pushes expected words; a negedge monitor pops on each output pop.
module tb_mux_rr_stream;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int SW = 3;

    typedef struct packed {
        logic [SW-1:0] ch;
        logic [DW-1:0] d;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    rdy;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [DW-1:0]   dout;
    logic            ov;
    logic            ordy;
    logic [SW-1:0]   och;

    logic [6*DW-1:0] din6;
    logic [5:0]      vld6;
    logic [5:0]      rdy6;
    logic            mode6;
    logic [2:0]      sel6;
    logic [DW-1:0]   dout6;
    logic            ov6;
    logic            ordy6;
    logic [2:0]      och6;

    exp_t q[$];
    int   pass_n = 0;
    int   total_n = 0;
    int   pops = 0;
    int   pushes = 0;

    always #5 clk = ~clk;

    mux_rr_stream #(.N_CH(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (vld),
        .in_ready  (rdy),
        .mode      (mode),
        .sel       (sel),
        .out       (dout),
        .out_valid (ov),
        .out_ready (ordy),
        .out_ch    (och)
    );

    mux_rr_stream #(.N_CH(6), .DW(DW)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .in        (din6),
        .in_valid  (vld6),
        .in_ready  (rdy6),
        .mode      (mode6),
        .sel       (sel6),
        .out       (dout6),
        .out_valid (ov6),
        .out_ready (ordy6),
        .out_ch    (och6)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_grant(input int ch);
        logic [N-1:0] m;
        exp_t e;
        m = N'(1) << ch;
        #1;
        chk($sformatf("in_ready_ch%0d", ch), rdy, m);
        e.ch = SW'(ch);
        e.d  = 8'hA0 + DW'(ch);
        q.push_back(e);
        pushes++;
        tick();
    endtask

    task automatic exp_none();
        #1;
        chk("in_ready_none", rdy, 0);
        tick();
    endtask

    // Monitor: every accepted output word must match the queue head.
    always @(negedge clk) begin
        if (rst === 1'b0 && ov && ordy) begin
            exp_t e;
            if (q.size() == 0) begin
                total_n++;
                $display("FAIL unexpected_word: got ch %0d data %0h, expected none",
                         och, dout);
            end else begin
                e = q.pop_front();
                chk("out_data", dout, e.d);
                chk("out_ch", och, e.ch);
                pops++;
            end
        end
    end

    initial begin
        rst   = 1'b1;
        vld   = '1;
        mode  = 1'b1;
        sel   = '0;
        ordy  = 1'b1;
        vld6  = 6'h3F;
        mode6 = 1'b0;
        sel6  = 3'd7;
        ordy6 = 1'b1;
        for (int i = 0; i < N; i++) din[i*DW +: DW] = 8'hA0 + DW'(i);
        for (int i = 0; i < 6; i++) din6[i*DW +: DW] = 8'h50 + DW'(i);

        repeat (3) begin
            tick();
            chk("rst_out", dout, 0);
            chk("rst_out_valid", ov, 0);
            chk("rst_out_ch", och, 0);
            chk("rst_in_ready", rdy, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 9; i++) exp_grant(i % 8);

        vld = 8'h24;
        exp_grant(2);
        exp_grant(5);
        exp_grant(2);
        vld = 8'h04;
        repeat (3) exp_grant(2);

        mode = 1'b0;
        sel  = 3'd3;
        vld  = 8'hFF;
        repeat (3) exp_grant(3);
        vld = 8'hF7;
        exp_none();
        chk("dir_drop_valid", ov, 0);
        chk("dir_hold_ch", och, 3);
        chk("dir_hold_data", dout, 8'hA3);

        chk("n6_sel7_ready", rdy6, 0);
        chk("n6_sel7_valid", ov6, 0);
        sel6 = 3'd5;
        #1;
        chk("n6_sel5_ready", rdy6, 6'h20);
        tick();
        chk("n6_sel5_valid", ov6, 1);
        chk("n6_sel5_ch", och6, 5);
        chk("n6_sel5_data", dout6, 8'h55);
        sel6 = 3'd7;
        tick();
        chk("n6_sel7_drop", ov6, 0);
        chk("n6_sel7_ready2", rdy6, 0);

        mode = 1'b1;
        vld  = 8'hFF;
        exp_grant(3);

        ordy = 1'b0;
        repeat (4) begin
            #1;
            chk("bp_in_ready", rdy, 0);
            chk("bp_out_stable", dout, 8'hA3);
            chk("bp_out_valid", ov, 1);
            tick();
        end
        ordy = 1'b1;
        exp_grant(4);

        ordy = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", ov, 0);
        chk("midrst_ready", rdy, 0);
        chk("midrst_out", dout, 0);
        chk("midrst_queue", q.size(), 1);
        q.delete();
        tick();
        tick();
        rst  = 1'b0;
        ordy = 1'b1;
        exp_grant(0);
        exp_grant(1);
        vld = '0;

        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        chk("queue_drained", q.size(), 0);
        chk("pop_count", pops, pushes - 1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
